// File: rtl/vga_dec_pkg.sv
// Shared types, count widths and default 640x480 mode constants for the VGA sync decoder.
package vga_dec_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = 32;
  localparam int unsigned GOOD_W  = 4;

  // 640x480 @ 60 Hz defaults
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_LOCK_FRAMES = 2;
  localparam int unsigned DEF_TIMEOUT     = 1600;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  function automatic cnt_t cnt_sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  function automatic coord_t coord_sat_inc(input coord_t v);
    return (v == '1) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Falling-edge detector: registered previous sample (resets high) compared with the live input.
module vga_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic fall_c_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign fall_c_o = prev_q & ~sig_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers de/x/y, measures line/frame length and tracks mode lock.
// Optional frame checksum enabled by defining VGA_SYNC_DECODER_CHECKSUM_EN.
module vga_sync_decoder
  import vga_dec_pkg::*;
#(
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_blank_n,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic        o_de,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic [23:0] o_pix,
  output logic        o_sof,
  output logic [10:0] o_h_total,
  output logic [10:0] o_v_total,
  output logic        o_locked,
  output logic        o_err,
  output logic [31:0] o_frame_sum
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic hs_fall_c;
  logic vs_fall_c;

  vga_edge_det u_hs_edge (
    .clk_i    (i_clk),
    .rst_n_i  (i_rst_n),
    .sig_i    (i_hs),
    .fall_c_o (hs_fall_c)
  );

  vga_edge_det u_vs_edge (
    .clk_i    (i_clk),
    .rst_n_i  (i_rst_n),
    .sig_i    (i_vs),
    .fall_c_o (vs_fall_c)
  );

  cnt_t              h_cnt_q, h_cnt_d;
  cnt_t              line_cnt_q, line_cnt_d;
  coord_t            x_cnt_q, x_cnt_d;
  coord_t            y_cnt_q, y_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              frame_bad_q, frame_bad_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  lock_state_t       state_q, state_d;
  logic              err_q, err_d;

  logic              de_q;
  coord_t            x_out_q, y_out_q;
  logic [23:0]       pix_q;
  logic              sof_q;
  cnt_t              h_total_q, v_total_q;

  cnt_t              line_len_c;
  logic              line_bad_c;
  logic              frame_good_c;
  logic              timeout_c;
  coord_t            x_cur_c;
  coord_t            y_cur_c;

  // Line/frame measurement and coordinate recovery
  always_comb begin
    line_len_c   = cnt_sat_inc(h_cnt_q);
    line_bad_c   = hs_fall_c &&
                   ((line_len_c != cnt_t'(H_TOTAL)) ||
                    ((x_cnt_q != '0) && (x_cnt_q != coord_t'(H_ACTIVE))));
    // An hs fall coincident with vs fall closes a line of the outgoing frame.
    frame_good_c = !(frame_bad_q || line_bad_c) && (line_cnt_q == cnt_t'(V_TOTAL));
    timeout_c    = !hs_fall_c && (to_cnt_q == TO_W'(TIMEOUT - 1));

    x_cur_c = hs_fall_c ? '0 : x_cnt_q;
    y_cur_c = y_cnt_q;
    if (vs_fall_c) begin
      y_cur_c = '0;
    end else if (hs_fall_c && (x_cnt_q != '0)) begin
      y_cur_c = coord_sat_inc(y_cnt_q);
    end

    h_cnt_d    = hs_fall_c ? '0 : cnt_sat_inc(h_cnt_q);
    line_cnt_d = hs_fall_c ? cnt_sat_inc(line_cnt_q) : line_cnt_q;
    if (vs_fall_c) begin
      line_cnt_d = hs_fall_c ? cnt_t'(1) : '0;
    end

    x_cnt_d     = i_blank_n ? coord_sat_inc(x_cur_c) : x_cur_c;
    y_cnt_d     = y_cur_c;
    frame_bad_d = vs_fall_c ? 1'b0 : (frame_bad_q || line_bad_c);
    to_cnt_d    = (hs_fall_c || timeout_c) ? '0 : to_cnt_q + TO_W'(1);
  end

  // Lock FSM next-state
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = err_q;

    if (timeout_c) begin
      if (state_q == LOCKED) begin
        err_d = 1'b1;
      end
      state_d    = UNLOCKED;
      good_cnt_d = '0;
    end else if (vs_fall_c) begin
      case (state_q)
        UNLOCKED: begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
        CHECK: begin
          if (!frame_good_c) begin
            good_cnt_d = '0;
          end else if ((5'(good_cnt_q) + 5'd1) >= 5'(LOCK_FRAMES)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
        LOCKED: begin
          if (!frame_good_c) begin
            state_d    = UNLOCKED;
            err_d      = 1'b1;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = UNLOCKED;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt_q     <= '0;
      line_cnt_q  <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      to_cnt_q    <= '0;
      frame_bad_q <= 1'b0;
      good_cnt_q  <= '0;
      state_q     <= UNLOCKED;
      err_q       <= 1'b0;
      de_q        <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      pix_q       <= '0;
      sof_q       <= 1'b0;
      h_total_q   <= '0;
      v_total_q   <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      line_cnt_q  <= line_cnt_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      to_cnt_q    <= to_cnt_d;
      frame_bad_q <= frame_bad_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
      err_q       <= err_d;
      de_q        <= i_blank_n;
      x_out_q     <= x_cur_c;
      y_out_q     <= y_cur_c;
      pix_q       <= {i_r, i_g, i_b};
      sof_q       <= vs_fall_c;
      if (hs_fall_c) begin
        h_total_q <= line_len_c;
      end
      if (vs_fall_c) begin
        v_total_q <= line_cnt_q;
      end
    end
  end

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] contrib_c;

  // Per-frame R+G+B accumulator, handed off at each vs fall
  always_comb begin
    contrib_c = i_blank_n ? (SUM_W'(i_r) + SUM_W'(i_g) + SUM_W'(i_b)) : '0;
    acc_d     = vs_fall_c ? contrib_c : acc_q + contrib_c;
    sum_d     = vs_fall_c ? acc_q : sum_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign o_frame_sum = sum_q;
`else
  assign o_frame_sum = 32'd0;
`endif

  assign o_de      = de_q;
  assign o_x       = x_out_q;
  assign o_y       = y_out_q;
  assign o_pix     = pix_q;
  assign o_sof     = sof_q;
  assign o_h_total = h_total_q;
  assign o_v_total = v_total_q;
  assign o_locked  = (state_q == LOCKED);
  assign o_err     = err_q;

endmodule
